// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared FSM encoding, opcodes and iteration count for multdiv_unit
package multdiv_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_e;
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV = 1'b1;
  localparam int ITER = 32;
  function automatic logic [32:0] mag33(input logic [31:0] x);
    logic [32:0] s;
    s = {x[31], x};
    return x[31] ? (~s + 33'd1) : s;
  endfunction
endpackage

// File: rtl/addsub33.sv
// addsub33: 33-bit adder/subtractor shared by the multiply and divide steps
module addsub33 (
  input  logic [32:0] a,
  input  logic [32:0] b,
  input  logic        sub,
  output logic [32:0] y
);
  assign y = sub ? a - b : a + b;
endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed 32x32 multiply / 32/32 divide, one radix-2 step per cycle
module multdiv_unit import multdiv_pkg::*; #(
  parameter int ITER = multdiv_pkg::ITER
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);
  state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [64:0] acc_q, acc_d;
  logic [32:0] m_q, m_d;
  logic op_q, op_d, neg_q, neg_d;
  logic [31:0] res_q, res_d;
  logic exc_q, exc_d, rdy_q, rdy_d;
  logic start, sub;
  logic [32:0] as_a, as_b, as_y, mag_lo;
  logic [31:0] quo, quo_s;
  logic [63:0] prod, prod_s;

  addsub33 u_addsub (.a(as_a), .b(as_b), .sub(sub), .y(as_y));

  assign start = ctrl_MULT | ctrl_DIV;
  assign sub = op_q == OP_DIV;
  // divide shifts the remainder left before trial-subtracting; multiply adds in place then shifts right
  assign as_a = sub ? {acc_q[63:32], acc_q[31]} : acc_q[64:32];
  assign as_b = (sub | acc_q[0]) ? m_q : 33'd0;
  assign mag_lo = mag33(ctrl_MULT ? data_operandB : data_operandA);
  assign prod = acc_q[63:0];
  assign prod_s = neg_q ? -prod : prod;
  assign quo = acc_q[31:0];
  assign quo_s = neg_q ? -quo : quo;

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    m_d = m_q;
    op_d = op_q;
    neg_d = neg_q;
    res_d = res_q;
    exc_d = exc_q;
    rdy_d = 1'b0;
    if (state_q == RUN) begin
      if (cnt_q == 6'(ITER)) begin
        state_d = DONE;
        rdy_d = 1'b1;
        res_d = sub ? ((m_q == 33'd0) ? 32'd0 : quo_s) : prod_s[31:0];
        exc_d = sub ? ((m_q == 33'd0) | (~neg_q & quo[31])) : (prod_s[63:32] != {32{prod_s[31]}});
      end else begin
        cnt_d = cnt_q + 6'd1;
        acc_d = sub ? (as_y[32] ? {acc_q[63:0], 1'b0} : {as_y, acc_q[30:0], 1'b1})
                    : {1'b0, as_y, acc_q[31:1]};
      end
    end else if (start) begin
      state_d = RUN;
      cnt_d = 6'd0;
      op_d = ctrl_MULT ? OP_MULT : OP_DIV;
      neg_d = data_operandA[31] ^ data_operandB[31];
      m_d = mag33(ctrl_MULT ? data_operandA : data_operandB);
      acc_d = {33'd0, mag_lo[31:0]};
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= 6'd0;
      acc_q <= 65'd0;
      m_q <= 33'd0;
      op_q <= OP_MULT;
      neg_q <= 1'b0;
      res_q <= 32'd0;
      exc_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      m_q <= m_d;
      op_q <= op_d;
      neg_q <= neg_d;
      res_q <= res_d;
      exc_q <= exc_d;
      rdy_q <= rdy_d;
    end
  end

  assign data_result = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: directed checks of multdiv_unit latency, results, exceptions and reset abort
module tb_multdiv_unit;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [31:0] data_operandA = '0, data_operandB = '0;
  logic ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic data_exception, data_resultRDY;
  int vec = 0, errs = 0;
  int n, strobes;

  multdiv_unit #(.ITER(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT = m;
    ctrl_DIV = d;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
  endtask

  task automatic wait_rdy(output int c);
    c = 0;
    while (!data_resultRDY && c < 40) begin
      @(posedge clock);
      #1;
      c++;
    end
  endtask

  task automatic op_check(input string tag, input logic m, input logic d, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic ee);
    int c;
    start_op(m, d, a, b);
    wait_rdy(c);
    chk({tag, "_lat"}, 32'(c), 32'd33);
    chk({tag, "_res"}, data_result, er);
    chk({tag, "_exc"}, {31'd0, data_exception}, {31'd0, ee});
  endtask

  initial begin
    #1;
    chk("rst_res", data_result, 32'd0);
    chk("rst_exc", {31'd0, data_exception}, 32'd0);
    chk("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    op_check("mul_7_m3", 1'b1, 1'b0, 32'd7, -32'sd3, 32'hFFFFFFEB, 1'b0);
    @(posedge clock);
    #1;
    chk("rdy_one_cycle", {31'd0, data_resultRDY}, 32'd0);
    chk("res_hold", data_result, 32'hFFFFFFEB);

    op_check("mul_ovf", 1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1);
    op_check("div_m7_2", 1'b0, 1'b1, -32'sd7, 32'd2, 32'hFFFFFFFD, 1'b0);
    op_check("div_by_0", 1'b0, 1'b1, 32'd5, 32'd0, 32'h00000000, 1'b1);
    op_check("div_min_m1", 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);

    start_op(1'b1, 1'b1, 32'd6, 32'd3);
    repeat (10) @(posedge clock);
    @(negedge clock);
    ctrl_DIV = 1'b1;
    data_operandA = 32'd100;
    data_operandB = 32'd10;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    wait_rdy(n);
    chk("both_lat", 32'(n), 32'd22);
    chk("both_res", data_result, 32'd18);
    chk("both_exc", {31'd0, data_exception}, 32'd0);

    op_check("mul_6_7", 1'b1, 1'b0, 32'd6, 32'd7, 32'd42, 1'b0);
    ctrl_DIV = 1'b1;
    data_operandA = 32'd100;
    data_operandB = 32'd10;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    chk("b2b_gap_low", {31'd0, data_resultRDY}, 32'd0);
    wait_rdy(n);
    chk("b2b_lat", 32'(n), 32'd33);
    chk("b2b_res", data_result, 32'd10);
    chk("b2b_exc", {31'd0, data_exception}, 32'd0);

    start_op(1'b1, 1'b0, 32'h00010000, 32'h00010000);
    repeat (15) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_res", data_result, 32'd0);
    chk("abort_exc", {31'd0, data_exception}, 32'd0);
    chk("abort_rdy", {31'd0, data_resultRDY}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    strobes = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) strobes++;
    end
    chk("abort_no_strobe", 32'(strobes), 32'd0);
    op_check("post_rst_div", 1'b0, 1'b1, 32'd100, -32'sd10, 32'hFFFFFFF6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
